// File: rtl/sprite_bus_pkg.sv
// Shared types and constants for the sprite flusher: FSM state enum, bus addresses, word type.
// SPRITE_FLUSH_CLEAR_EN adds the StClr state.
package sprite_bus_pkg;

  localparam logic [5:0]  VSYNC_ADDR_C  = 6'd61;
  localparam logic [5:0]  CLEAR_ADDR_C  = 6'd60;
  localparam int unsigned MAX_SPRITES_C = 30;

  typedef logic [31:0] sprite_word_t;

  typedef enum logic [2:0] {
    StIdle,
    StPollRd,
    StPollWait,
    StScan,
    StWr,
    StDone
`ifdef SPRITE_FLUSH_CLEAR_EN
    , StClr
`endif
  } flush_state_e;

endpackage

// File: rtl/avalon_sprite_flusher_if.sv
// Avalon-MM signal bundle between the sprite flusher (master) and the sprite register peripheral.
interface avalon_sprite_flusher_if;

  logic [5:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/sprite_shadow_table.sv
// Shadow copy of the sprite descriptor words with per-entry dirty bits.
// A table write in the same cycle as a flush clear keeps the entry dirty.
module sprite_shadow_table import sprite_bus_pkg::*; #(
  parameter int unsigned NUM_SPRITES = MAX_SPRITES_C
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [4:0]   waddr,
  input  sprite_word_t wdata,
  input  logic         clr,
  input  logic [4:0]   clr_addr,
  input  logic [4:0]   rd_addr,
  output sprite_word_t rd_data,
  output logic         rd_dirty
);

  sprite_word_t           mem_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dirty_q;
  logic                   we_ok;
  logic                   rd_ok;

  assign we_ok = we && (int'(waddr) < int'(NUM_SPRITES));
  assign rd_ok = int'(rd_addr) < int'(NUM_SPRITES);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        mem_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      if (we_ok) begin
        mem_q[waddr] <= wdata;
      end
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        if (we_ok && int'(waddr) == i) begin
          dirty_q[i] <= 1'b1;
        end else if (clr && int'(clr_addr) == i) begin
          dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_dirty = 1'b0;
    if (rd_ok) begin
      rd_data  = mem_q[rd_addr];
      rd_dirty = dirty_q[rd_addr];
    end
  end

endmodule

// File: rtl/avalon_sprite_flusher.sv
// Avalon-MM master that pushes dirty shadow sprite words to the peripheral on vsync or request.
// SPRITE_FLUSH_CLEAR_EN: each flush first writes CLEAR_ADDR, then rewrites every nonzero entry.
module avalon_sprite_flusher import sprite_bus_pkg::*; #(
  parameter int unsigned NUM_SPRITES  = MAX_SPRITES_C,
  parameter logic [5:0]  VSYNC_ADDR   = VSYNC_ADDR_C,
  parameter logic [5:0]  CLEAR_ADDR   = CLEAR_ADDR_C,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          AUTO_VSYNC   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tbl_we,
  input  logic [4:0]                     tbl_addr,
  input  sprite_word_t                   tbl_wdata,
  input  logic                           flush_req,
  avalon_sprite_flusher_if.master        avm,
  output logic                           busy,
  output logic                           frame_done,
  output logic [15:0]                    frame_count
);

  flush_state_e state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  sprite_word_t wr_data_q, wr_data_d;
  logic [7:0]   lat_cnt_q, lat_cnt_d;
  logic         hist_q, hist_d;
  logic         pending_q, pending_d;
  logic [15:0]  frame_count_q, frame_count_d;

  sprite_word_t rd_data;
  logic         rd_dirty;
  logic         scan_hit;
  logic         clr_dirty;
  logic         start_flush;
  logic         unused_cfg;
  logic         unused_rd;

  sprite_shadow_table #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (tbl_we),
    .waddr    (tbl_addr),
    .wdata    (tbl_wdata),
    .clr      (clr_dirty),
    .clr_addr (idx_q),
    .rd_addr  (idx_q),
    .rd_data  (rd_data),
    .rd_dirty (rd_dirty)
  );

`ifdef SPRITE_FLUSH_CLEAR_EN
  // The peripheral was just zeroed, so every nonzero word must be restored.
  assign scan_hit   = (rd_data != '0);
  assign unused_cfg = rd_dirty;
`else
  assign scan_hit   = rd_dirty;
  assign unused_cfg = ^CLEAR_ADDR;
`endif
  assign unused_rd = ^avm.avm_readdata[31:1];

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    wr_data_d         = wr_data_q;
    lat_cnt_d         = lat_cnt_q;
    hist_d            = hist_q;
    pending_d         = pending_q;
    frame_count_d     = frame_count_q;
    start_flush       = 1'b0;
    clr_dirty         = 1'b0;
    frame_done        = 1'b0;
    avm.avm_address   = '0;
    avm.avm_write     = 1'b0;
    avm.avm_read      = 1'b0;
    avm.avm_writedata = '0;

    unique case (state_q)
      StIdle: begin
        if (AUTO_VSYNC) begin
          state_d = StPollRd;
        end else if (pending_q || flush_req) begin
          start_flush = 1'b1;
        end
      end
      StPollRd: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = VSYNC_ADDR;
        if (!avm.avm_waitrequest) begin
          state_d   = StPollWait;
          lat_cnt_d = 8'd1;
        end
      end
      StPollWait: begin
        if (lat_cnt_q >= 8'(READ_LATENCY)) begin
          hist_d = avm.avm_readdata[0];
          if (hist_q && !avm.avm_readdata[0]) begin
            start_flush = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
`ifdef SPRITE_FLUSH_CLEAR_EN
      StClr: begin
        avm.avm_write   = 1'b1;
        avm.avm_address = CLEAR_ADDR;
        if (!avm.avm_waitrequest) begin
          state_d = StScan;
        end
      end
`endif
      StScan: begin
        // Index past the table after a write to the last entry.
        if (int'(idx_q) >= int'(NUM_SPRITES)) begin
          state_d = StDone;
        end else if (scan_hit) begin
          wr_data_d = rd_data;
          state_d   = StWr;
        end else if (int'(idx_q) == int'(NUM_SPRITES) - 1) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      StWr: begin
        avm.avm_write     = 1'b1;
        avm.avm_address   = {1'b0, idx_q};
        avm.avm_writedata = wr_data_q;
        if (!avm.avm_waitrequest) begin
          clr_dirty = 1'b1;
          idx_d     = idx_q + 5'd1;
          state_d   = StScan;
        end
      end
      StDone: begin
        frame_done    = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start_flush) begin
      idx_d     = '0;
      pending_d = 1'b0;
`ifdef SPRITE_FLUSH_CLEAR_EN
      state_d   = StClr;
`else
      state_d   = StScan;
`endif
    end
    if (flush_req && state_q != StIdle) begin
      pending_d = 1'b1;
    end

    avm.avm_chipselect = avm.avm_read | avm.avm_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      wr_data_q     <= '0;
      lat_cnt_q     <= '0;
      hist_q        <= 1'b1;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_data_q     <= wr_data_d;
      lat_cnt_q     <= lat_cnt_d;
      hist_q        <= hist_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_avalon_sprite_flusher.sv
// Scoreboard bench: dut_a runs vsync polling, dut_m runs manual flush requests.
// Expected bus writes are queued as stimulus is applied and popped on each accepted write.
module tb_avalon_sprite_flusher;
  import sprite_bus_pkg::*;

  localparam int NS = 30;
`ifdef SPRITE_FLUSH_CLEAR_EN
  localparam int CLR_EXTRA = 1;
`else
  localparam int CLR_EXTRA = 0;
`endif

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_m, tbl_we_a, tbl_we_m, flush_req_a, flush_req_m;
  logic [4:0]  tbl_addr_a, tbl_addr_m;
  logic [31:0] tbl_wdata_a, tbl_wdata_m;
  logic        busy_a, busy_m, fd_a, fd_m;
  logic [15:0] fc_a, fc_m;

  avalon_sprite_flusher_if bus_a ();
  avalon_sprite_flusher_if bus_m ();

  int total = 0;
  int bad = 0;
  wr_t exp_a[$];
  wr_t exp_m[$];
  int fd_cnt_a = 0;
  int fd_cnt_m = 0;
  int stall_seen_a = 0;
  int stall_lim_a = 0;
  logic stall_m = 1'b0;
  logic [31:0] vs_seq [16];
  int vs_wr = 0;
  int vs_rd = 0;

  assign bus_a.avm_waitrequest = bus_a.avm_write && (bus_a.avm_address == 6'd3) &&
                                 (stall_seen_a < stall_lim_a);
  assign bus_m.avm_waitrequest = bus_m.avm_write && stall_m;
  assign bus_m.avm_readdata    = '0;

  avalon_sprite_flusher #(.AUTO_VSYNC(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .tbl_we(tbl_we_a), .tbl_addr(tbl_addr_a),
    .tbl_wdata(tbl_wdata_a), .flush_req(flush_req_a), .avm(bus_a), .busy(busy_a),
    .frame_done(fd_a), .frame_count(fc_a)
  );

  avalon_sprite_flusher #(.AUTO_VSYNC(1'b0)) dut_m (
    .clk(clk), .reset(reset_m), .tbl_we(tbl_we_m), .tbl_addr(tbl_addr_m),
    .tbl_wdata(tbl_wdata_m), .flush_req(flush_req_m), .avm(bus_m), .busy(busy_m),
    .frame_done(fd_m), .frame_count(fc_m)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tbl_write_a(input logic [4:0] a, input logic [31:0] d);
    tbl_we_a = 1'b1; tbl_addr_a = a; tbl_wdata_a = d;
    @(negedge clk);
    tbl_we_a = 1'b0;
  endtask

  task automatic tbl_write_m(input logic [4:0] a, input logic [31:0] d);
    tbl_we_m = 1'b1; tbl_addr_m = a; tbl_wdata_m = d;
    @(negedge clk);
    tbl_we_m = 1'b0;
  endtask

  task automatic wait_fd_a(input int target, input int max);
    int k = 0;
    while (fd_cnt_a < target && k < max) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("a_fd_wait", fd_cnt_a, target);
  endtask

  task automatic wait_fd_m(input int target, input int max);
    int k = 0;
    while (fd_cnt_m < target && k < max) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("m_fd_wait", fd_cnt_m, target);
  endtask

  // Pulses flush_req at the current negedge; returns cycles until frame_done is seen.
  task automatic flush_latency_m(input int repulse_at, output int k);
    flush_req_m = 1'b1;
    @(negedge clk);
    flush_req_m = 1'b0;
    k = 1;
    while (!fd_m && k < 300) begin
      @(negedge clk);
      flush_req_m = (k == repulse_at);
      k++;
    end
    flush_req_m = 1'b0;
  endtask

  // Vsync slave model and stall accounting for dut_a.
  initial begin
    logic take, stl;
    bus_a.avm_readdata <= 32'd1;
    forever begin
      @(negedge clk);
      take = bus_a.avm_read && !bus_a.avm_waitrequest;
      stl  = bus_a.avm_waitrequest;
      @(posedge clk);
      if (take && vs_rd != vs_wr) begin
        bus_a.avm_readdata <= vs_seq[vs_rd];
        vs_rd++;
      end
      if (stl) stall_seen_a <= stall_seen_a + 1;
    end
  end

  initial begin
    logic       prev_stall;
    logic [5:0] prev_addr;
    logic [31:0] prev_data;
    wr_t e;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      check("a_cs", bus_a.avm_chipselect, bus_a.avm_read | bus_a.avm_write);
      if (bus_a.avm_read && bus_a.avm_write) check("a_rw_excl", 1'b1, 1'b0);
      if (prev_stall) begin
        check("a_stall_write", bus_a.avm_write, 1'b1);
        check("a_stall_addr", bus_a.avm_address, prev_addr);
        check("a_stall_data", bus_a.avm_writedata, prev_data);
      end
      if (bus_a.avm_write && !bus_a.avm_waitrequest) begin
        check("a_wr_expected", exp_a.size() != 0, 1'b1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_wr_addr", bus_a.avm_address, e.addr);
          check("a_wr_data", bus_a.avm_writedata, e.data);
        end
      end
      prev_stall = bus_a.avm_write && bus_a.avm_waitrequest;
      prev_addr  = bus_a.avm_address;
      prev_data  = bus_a.avm_writedata;
      if (fd_a) fd_cnt_a++;
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      check("m_cs", bus_m.avm_chipselect, bus_m.avm_read | bus_m.avm_write);
      check("m_no_read", bus_m.avm_read, 1'b0);
      if (bus_m.avm_write && !bus_m.avm_waitrequest) begin
        check("m_wr_expected", exp_m.size() != 0, 1'b1);
        if (exp_m.size() != 0) begin
          e = exp_m.pop_front();
          check("m_wr_addr", bus_m.avm_address, e.addr);
          check("m_wr_data", bus_m.avm_writedata, e.data);
        end
      end
      if (fd_m) fd_cnt_m++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset_a = 1'b1; reset_m = 1'b1;
    tbl_we_a = 1'b0; tbl_we_m = 1'b0; flush_req_a = 1'b0; flush_req_m = 1'b0;
    tbl_addr_a = '0; tbl_addr_m = '0; tbl_wdata_a = '0; tbl_wdata_m = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_write_a", bus_a.avm_write, 1'b0);
    check("rst_read_a", bus_a.avm_read, 1'b0);
    check("rst_addr_a", bus_a.avm_address, 6'd0);
    check("rst_fd_a", fd_a, 1'b0);
    check("rst_fc_a", fc_a, 16'd0);
    check("rst_busy_m", busy_m, 1'b0);
    check("rst_fc_m", fc_m, 16'd0);
    reset_a = 1'b0; reset_m = 1'b0;
    @(negedge clk);

    // Frame 1: two dirty entries, stalled first sprite write, same-cycle rewrite of entry 3.
    tbl_write_a(5'd30, 32'h12345678);
    tbl_write_a(5'd3, 32'hDEADBEEF);
    tbl_write_a(5'd17, 32'h00010002);
    stall_lim_a = 5;
    if (CLR_EXTRA != 0) exp_a.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
    exp_a.push_back('{addr: 6'd3, data: 32'hDEADBEEF});
    exp_a.push_back('{addr: 6'd17, data: 32'h00010002});
    vs_seq[0] = 32'd1; vs_seq[1] = 32'd1; vs_seq[2] = 32'd0;
    vs_wr = 3;
    k = 0;
    while (!(bus_a.avm_write && bus_a.avm_address == 6'd3 && !bus_a.avm_waitrequest) &&
           k < 500) begin
      @(negedge clk);
      k++;
    end
    check("a_accept_seen", k < 500, 1'b1);
    tbl_write_a(5'd3, 32'h11111111);
    wait_fd_a(1, 500);
    repeat (20) @(negedge clk);
    check("a_fd_once", fd_cnt_a, 1);
    check("a_fc1", fc_a, 16'd1);
    check("a_exp_empty1", exp_a.size(), 0);
    check("a_stall_cycles", stall_seen_a, 5);

    // Frame 2: entry 3 stayed dirty and carries the rewritten word.
    if (CLR_EXTRA != 0) exp_a.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
    exp_a.push_back('{addr: 6'd3, data: 32'h11111111});
    if (CLR_EXTRA != 0) exp_a.push_back('{addr: 6'd17, data: 32'h00010002});
    vs_seq[3] = 32'd1; vs_seq[4] = 32'd0;
    vs_wr = 5;
    wait_fd_a(2, 500);
    check("a_fc2", fc_a, 16'd2);
    check("a_exp_empty2", exp_a.size(), 0);

    // Manual flush with an empty table, plus a request while busy.
    if (CLR_EXTRA != 0) begin
      exp_m.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
      exp_m.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
    end
    flush_latency_m(10, k);
    check("m_fd_latency", k, NS + 1 + CLR_EXTRA);
    wait_fd_m(2, 200);
    check("m_fc2", fc_m, 16'd2);
    check("m_exp_empty1", exp_m.size(), 0);

    // Reset during a stalled write.
    tbl_write_m(5'd2, 32'h000000AA);
    tbl_write_m(5'd9, 32'hBBBB0000);
    stall_m = 1'b1;
    flush_req_m = 1'b1;
    @(negedge clk);
    flush_req_m = 1'b0;
    k = 0;
    while (!bus_m.avm_write && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("m_wr_started", bus_m.avm_write, 1'b1);
    repeat (3) @(negedge clk);
    check("m_still_stalled", bus_m.avm_write, 1'b1);
    check("m_busy_stalled", busy_m, 1'b1);
    reset_m = 1'b1;
    @(negedge clk);
    check("m_rst_write", bus_m.avm_write, 1'b0);
    check("m_rst_fc", fc_m, 16'd0);
    check("m_rst_busy", busy_m, 1'b0);
    stall_m = 1'b0;
    reset_m = 1'b0;
    @(negedge clk);
    check("m_no_fd_on_reset", fd_cnt_m, 2);
    if (CLR_EXTRA != 0) exp_m.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
    flush_latency_m(-1, k);
    check("m_fd_after_reset", k, NS + 1 + CLR_EXTRA);
    wait_fd_m(3, 100);
    check("m_fc_after_reset", fc_m, 16'd1);
    check("m_exp_empty2", exp_m.size(), 0);

`ifdef SPRITE_FLUSH_CLEAR_EN
    // Clean nonzero entries are restored after the clear write.
    tbl_write_m(5'd5, 32'hA5A5A5A5);
    exp_m.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
    exp_m.push_back('{addr: 6'd5, data: 32'hA5A5A5A5});
    flush_latency_m(-1, k);
    wait_fd_m(4, 100);
    exp_m.push_back('{addr: CLEAR_ADDR_C, data: 32'd0});
    exp_m.push_back('{addr: 6'd5, data: 32'hA5A5A5A5});
    flush_latency_m(-1, k);
    wait_fd_m(5, 100);
    check("m_clr_exp_empty", exp_m.size(), 0);
    check("m_clr_fc", fc_m, 16'd3);
`endif

    repeat (5) @(negedge clk);
    check("a_exp_final", exp_a.size(), 0);
    check("m_exp_final", exp_m.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_sprite_flusher.md
Name: avalon_sprite_flusher

Overview:
- Avalon-MM master that drives the sprite register peripheral from the hardware side.
- Keeps a local shadow table of sprite descriptor words with per-entry dirty bits.
- Polls the peripheral's vsync status register, or accepts a manual request, then pushes only the dirty entries as Avalon writes.
- Lets game logic in fabric update sprites without the HPS touching the bus every frame.

Parameters:
- NUM_SPRITES, 30: shadow entries; entry i is written to peripheral address i.
- VSYNC_ADDR, 61: peripheral address of the vsync status word.
- CLEAR_ADDR, 60: peripheral address whose write zeroes all sprite registers.
- READ_LATENCY, 1: fixed cycles from an accepted read to valid avm_readdata.
- AUTO_VSYNC, 1: 1 = flushes are triggered by vsync polling; 0 = flushes are triggered by flush_req only.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- tbl_we  in  1  shadow table write strobe
- tbl_addr  in  5  shadow entry index; writes with index >= NUM_SPRITES are ignored
- tbl_wdata  in  32  sprite descriptor word
- flush_req  in  1  one-cycle manual flush request
- avm_address  out  6  Avalon word address
- avm_chipselect  out  1  asserted whenever avm_read or avm_write is asserted
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at the end of each flush
- frame_count  out  16  completed flushes, wraps at 16 bits

Behaviour:
- Reset is synchronous, active-high, on clock clk. On reset:
  - all shadow entries = 0 and all dirty bits = 0;
  - all outputs = 0;
  - state = IDLE, internal vsync history = 1, pending flag = 0.
- Reset mid-transfer abandons the transfer immediately: no completion pulse, and outputs drop the next cycle.
- Shadow write: when tbl_we is high and the index is valid, the entry takes tbl_wdata and its dirty bit is set, in every state.
- Avalon rules:
  - A request is held with address, data and strobes stable until a cycle where avm_waitrequest = 0; that cycle is the accept.
  - avm_writedata comes from an issue latch, never from the live table.
- FSM states: IDLE, POLL_RD, POLL_WAIT, SCAN, WR, DONE (plus CLR when the optional feature is compiled in).
- IDLE:
  - AUTO_VSYNC = 1: go to POLL_RD.
  - AUTO_VSYNC = 0: go to SCAN when a flush is pending or flush_req is high.
  - flush_req arriving in any non-IDLE state sets the pending flag, which is consumed on entry to SCAN.
- POLL_RD: assert avm_read with avm_address = VSYNC_ADDR until accepted, then go to POLL_WAIT.
- POLL_WAIT:
  - Wait READ_LATENCY cycles, then sample avm_readdata[0].
  - A falling edge (history 1, sample 0) → SCAN.
  - Otherwise → IDLE.
  - The sample always updates the history.
- SCAN:
  - The index starts at 0 and examines one entry per cycle.
  - A dirty entry → latch its index and data, go to WR.
  - Past index NUM_SPRITES-1 → DONE.
- WR:
  - avm_write with avm_address = latched index.
  - On accept, clear that dirty bit, unless tbl_we targets the same index in that cycle; then the bit stays set and the new data goes out next frame.
  - Then index+1 and return to SCAN.
- DONE: pulse frame_done, increment frame_count, go to IDLE.
- A flush with no dirty entries still produces DONE after NUM_SPRITES SCAN cycles.
- avm_read and avm_write are never high together.

Optional Feature:
- Macro: SPRITE_FLUSH_CLEAR_EN.
- Defined:
  - Every flush first enters CLR: write 0 to CLEAR_ADDR and wait for accept.
  - SCAN then writes every entry with a nonzero word, regardless of dirty state.
  - Dirty bits of written entries are cleared, with the same same-cycle rule as WR.
- Undefined: the CLR state is absent and only dirty entries are written.

Decomposition:
- Package sprite_bus_pkg holds:
  - the state enum;
  - constants VSYNC_ADDR_C = 6'd61, CLEAR_ADDR_C = 6'd60, MAX_SPRITES_C = 30;
  - typedef sprite_word_t (logic [31:0]).
- One sub-module, sprite_shadow_table, holds the register array, the dirty vector and the same-cycle clear/set priority.

Test Plan:
- Write tbl entries 3 = 0xDEADBEEF and 17 = 0x00010002. Readdata[0] sequence 1,1,0 → exactly two writes, to addr 3 then addr 17, with matching data; frame_done pulses once; frame_count = 1.
- Stall with waitrequest high for 5 cycles on the addr 3 write → address and data stable across all 5 cycles; a single accept.
- tbl_we to entry 3 = 0x11111111 in the accept cycle of the addr 3 write → entry 3 stays dirty; the next vsync edge writes 0x11111111.
- AUTO_VSYNC = 0, no dirty entries, flush_req → no writes; frame_done pulses NUM_SPRITES+1 cycles later. A second flush_req while busy → a second flush follows.
- Assert reset during a stalled write → avm_write = 0 and frame_count = 0 next cycle; all dirty bits cleared.
- SPRITE_FLUSH_CLEAR_EN defined, entry 5 nonzero and clean → write to addr 60 first, then a write to addr 5.
